// File: rtl/mult_reg_datapath_if.sv
// rtl/mult_reg_datapath_if.sv - strobe, operand and display bus between multiplier FSM and datapath
interface mult_reg_datapath_if #(parameter int WIDTH = 8);
   logic             Clr_ld;
   logic             Shift;
   logic             Add;
   logic             Sub;
   logic [WIDTH-1:0] S;
   logic [WIDTH-1:0] Aval;
   logic [WIDTH-1:0] Bval;
   logic             X;
   logic             M;
   logic [6:0]       AhexU;
   logic [6:0]       AhexL;
   logic [6:0]       BhexU;
   logic [6:0]       BhexL;

   modport master (
      output Clr_ld, Shift, Add, Sub, S,
      input  Aval, Bval, X, M, AhexU, AhexL, BhexU, BhexL
   );

   modport slave (
      input  Clr_ld, Shift, Add, Sub, S,
      output Aval, Bval, X, M, AhexU, AhexL, BhexU, BhexL
   );
endinterface

// File: rtl/mult_reg_datapath.sv
// rtl/mult_reg_datapath.sv - X/A/B registers, 9-bit add/sub and hex display for the shift-add multiplier
module mult_reg_datapath #(
   parameter int WIDTH          = 8,
   parameter bit HEX_ACTIVE_LOW = 1'b1
) (
   input  logic                  Clk,
   input  logic                  Reset,
   mult_reg_datapath_if.slave    bus
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_x;
   logic [WIDTH:0]   w_operand;
   logic [WIDTH:0]   w_sum;
   logic             w_arith;

   // Subtract as A + ~S + 1 on sign-extended operands; Sub overrides Add.
   assign w_arith   = bus.Add | bus.Sub;
   assign w_operand = bus.Sub ? ~{bus.S[WIDTH-1], bus.S} : {bus.S[WIDTH-1], bus.S};
   assign w_sum     = {r_a[WIDTH-1], r_a} + w_operand + {{WIDTH{1'b0}}, bus.Sub};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_a <= '0;
         r_b <= '0;
         r_x <= 1'b0;
      end else if (bus.Clr_ld) begin
         r_a <= '0;
         r_b <= bus.S;
         r_x <= 1'b0;
      end else if (w_arith && bus.Shift) begin
         r_x <= w_sum[WIDTH];
         r_a <= {w_sum[WIDTH], w_sum[WIDTH-1:1]};
         r_b <= {w_sum[0], r_b[WIDTH-1:1]};
      end else if (w_arith) begin
         r_x <= w_sum[WIDTH];
         r_a <= w_sum[WIDTH-1:0];
      end else if (bus.Shift) begin
         r_a <= {r_x, r_a[WIDTH-1:1]};
         r_b <= {r_a[0], r_b[WIDTH-1:1]};
      end
   end

   function automatic logic [6:0] f_hex(input logic [3:0] i_nib);
      logic [6:0] w_seg;
      case (i_nib)
         4'h0: w_seg = 7'b1000000;
         4'h1: w_seg = 7'b1111001;
         4'h2: w_seg = 7'b0100100;
         4'h3: w_seg = 7'b0110000;
         4'h4: w_seg = 7'b0011001;
         4'h5: w_seg = 7'b0010010;
         4'h6: w_seg = 7'b0000010;
         4'h7: w_seg = 7'b1111000;
         4'h8: w_seg = 7'b0000000;
         4'h9: w_seg = 7'b0010000;
         4'hA: w_seg = 7'b0001000;
         4'hB: w_seg = 7'b0000011;
         4'hC: w_seg = 7'b1000110;
         4'hD: w_seg = 7'b0100001;
         4'hE: w_seg = 7'b0000110;
         default: w_seg = 7'b0001110;
      endcase
      return HEX_ACTIVE_LOW ? w_seg : ~w_seg;
   endfunction

   assign bus.Aval  = r_a;
   assign bus.Bval  = r_b;
   assign bus.X     = r_x;
   assign bus.M     = r_b[0];
   assign bus.AhexU = f_hex(r_a[WIDTH-1 -: 4]);
   assign bus.AhexL = f_hex(r_a[3:0]);
   assign bus.BhexU = f_hex(r_b[WIDTH-1 -: 4]);
   assign bus.BhexL = f_hex(r_b[3:0]);

endmodule

// File: tb/tb_mult_reg_datapath.sv
// tb/tb_mult_reg_datapath.sv - bench for mult_reg_datapath
module tb_mult_reg_datapath;

   logic Clk;
   logic Reset;
   int   n_vec;
   int   n_err;

   logic [7:0] m_a;
   logic [7:0] m_b;
   logic       m_x;
   logic [6:0] glyph [16];

   mult_reg_datapath_if #(.WIDTH(8)) bus ();

   mult_reg_datapath #(.WIDTH(8), .HEX_ACTIVE_LOW(1'b1)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic apply(input logic clr, input logic sh, input logic ad, input logic sb,
                        input logic [7:0] s);
      int         r;
      logic [8:0] r9;
      logic [16:0] t;
      bus.Clr_ld = clr;
      bus.Shift  = sh;
      bus.Add    = ad;
      bus.Sub    = sb;
      bus.S      = s;
      @(posedge Clk);
      #1;
      if (clr) begin
         m_a = 8'h00; m_x = 1'b0; m_b = s;
      end else if (ad || sb) begin
         r  = sb ? ($signed(m_a) - $signed(s)) : ($signed(m_a) + $signed(s));
         r9 = r[8:0];
         if (sh) begin
            t = {r9, m_b};
            t = {t[16], t[16:1]};
            {m_x, m_a, m_b} = t;
         end else begin
            m_x = r9[8]; m_a = r9[7:0];
         end
      end else if (sh) begin
         t = {m_x, m_a, m_b};
         t = {t[16], t[16:1]};
         {m_x, m_a, m_b} = t;
      end
      bus.Clr_ld = 1'b0; bus.Shift = 1'b0; bus.Add = 1'b0; bus.Sub = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      n_vec++;
      if ({bus.Aval, bus.Bval, bus.X, bus.M} !== 18'h0) begin
         n_err++; $display("FAIL reset_state: got A=%h B=%h X=%b M=%b, want all zero", bus.Aval, bus.Bval, bus.X, bus.M);
      end
      @(negedge Clk);
      Reset = 1'b0;
      m_a = 0; m_b = 0; m_x = 0;
   endtask

   task automatic test_reset_midop;
      apply(1, 0, 0, 0, 8'h33);
      apply(0, 0, 1, 0, 8'h80);
      apply(0, 0, 1, 0, 8'hDA);
      n_vec++;
      if ({bus.Aval, bus.Bval, bus.X} !== {8'h5A, 8'h33, 1'b1}) begin
         n_err++; $display("FAIL reset_preload: got A=%h B=%h X=%b, want 5a 33 1", bus.Aval, bus.Bval, bus.X);
      end
      #2 Reset = 1'b1;
      #1;
      n_vec++;
      if ({bus.Aval, bus.Bval, bus.X, bus.M} !== 18'h0) begin
         n_err++; $display("FAIL reset_async: got A=%h B=%h X=%b M=%b, want zero", bus.Aval, bus.Bval, bus.X, bus.M);
      end
      n_vec++;
      if ({bus.AhexU, bus.AhexL, bus.BhexU, bus.BhexL} !== {4{7'b1000000}}) begin
         n_err++; $display("FAIL reset_hex: got %b %b %b %b, want 1000000 x4", bus.AhexU, bus.AhexL, bus.BhexU, bus.BhexL);
      end
      bus.Clr_ld = 1'b1; bus.S = 8'hAA; bus.Add = 1'b1; bus.Shift = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      n_vec++;
      if ({bus.Aval, bus.Bval, bus.X} !== 17'h0) begin
         n_err++; $display("FAIL reset_hold: got A=%h B=%h X=%b, want zero", bus.Aval, bus.Bval, bus.X);
      end
      bus.Clr_ld = 1'b0; bus.Add = 1'b0; bus.Shift = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      m_a = 0; m_b = 0; m_x = 0;
   endtask

   task automatic test_clr_ld;
      apply(1, 0, 0, 0, 8'h00);
      apply(0, 0, 1, 0, 8'h80);
      apply(0, 0, 1, 0, 8'hFF);
      n_vec++;
      if ({bus.Aval, bus.X} !== {8'h7F, 1'b1}) begin
         n_err++; $display("FAIL clr_preload: got A=%h X=%b, want 7f 1", bus.Aval, bus.X);
      end
      apply(1, 1, 1, 0, 8'h03);
      n_vec++;
      if ({bus.Aval, bus.X, bus.Bval, bus.M} !== {8'h00, 1'b0, 8'h03, 1'b1}) begin
         n_err++; $display("FAIL clr_ld: got A=%h X=%b B=%h M=%b, want 00 0 03 1", bus.Aval, bus.X, bus.Bval, bus.M);
      end
   endtask

   task automatic test_add_shift;
      apply(1, 0, 0, 0, 8'h03);
      apply(0, 0, 1, 0, 8'h07);
      n_vec++;
      if ({bus.Aval, bus.X, bus.Bval} !== {8'h07, 1'b0, 8'h03}) begin
         n_err++; $display("FAIL add: got A=%h X=%b B=%h, want 07 0 03", bus.Aval, bus.X, bus.Bval);
      end
      apply(0, 1, 0, 0, 8'h07);
      n_vec++;
      if ({bus.Aval, bus.Bval, bus.X} !== {8'h03, 8'h81, 1'b0}) begin
         n_err++; $display("FAIL add_shift: got A=%h B=%h X=%b, want 03 81 0", bus.Aval, bus.Bval, bus.X);
      end
   endtask

   task automatic test_sub_sign;
      apply(1, 0, 0, 0, 8'h00);
      apply(0, 0, 0, 1, 8'h05);
      n_vec++;
      if ({bus.Aval, bus.X} !== {8'hFB, 1'b1}) begin
         n_err++; $display("FAIL sub: got A=%h X=%b, want fb 1", bus.Aval, bus.X);
      end
      apply(0, 1, 0, 0, 8'h05);
      n_vec++;
      if ({bus.Aval, bus.Bval[7], bus.X} !== {8'hFD, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL sub_shift: got A=%h B7=%b X=%b, want fd 1 1", bus.Aval, bus.Bval[7], bus.X);
      end
   endtask

   task automatic test_combined;
      apply(1, 0, 0, 0, 8'h01);
      apply(0, 0, 1, 0, 8'h02);
      apply(0, 1, 1, 1, 8'h05);
      n_vec++;
      if ({bus.X, bus.Aval, bus.Bval} !== {1'b1, 8'hFE, 8'h80}) begin
         n_err++; $display("FAIL sub_plus_shift: got X=%b A=%h B=%h, want 1 fe 80", bus.X, bus.Aval, bus.Bval);
      end
   endtask

   task automatic multiply(input logic [7:0] b, input logic [7:0] s);
      apply(1, 0, 0, 0, b);
      for (int i = 0; i < 7; i++) begin
         if (m_b[0]) apply(0, 0, 1, 0, s);
         apply(0, 1, 0, 0, s);
      end
      if (m_b[0]) apply(0, 1, 0, 1, s);
      else        apply(0, 1, 0, 0, s);
   endtask

   task automatic test_multiply;
      logic [7:0]  bs [3];
      logic [7:0]  ss [3];
      logic [15:0] want [3];
      logic [15:0] prod;
      bs = '{8'h03, 8'h03, 8'hFF};
      ss = '{8'h07, 8'hFE, 8'hFF};
      want = '{16'h0015, 16'hFFFA, 16'h0001};
      for (int k = 0; k < 23; k++) begin
         logic [7:0] b;
         logic [7:0] s;
         int         p;
         if (k < 3) begin b = bs[k]; s = ss[k]; prod = want[k]; end
         else begin
            b = 8'($urandom); s = 8'($urandom);
            p = $signed(b) * $signed(s);
            prod = p[15:0];
         end
         multiply(b, s);
         n_vec++;
         if ({bus.Aval, bus.Bval} !== prod || bus.X !== prod[15]) begin
            n_err++; $display("FAIL mult_%0d: %h*%h got {A,B}=%h X=%b, want %h X=%b", k, b, s, {bus.Aval, bus.Bval}, bus.X, prod, prod[15]);
         end
         n_vec++;
         if ({bus.AhexU, bus.AhexL, bus.BhexU, bus.BhexL} !==
             {glyph[prod[15:12]], glyph[prod[11:8]], glyph[prod[7:4]], glyph[prod[3:0]]}) begin
            n_err++; $display("FAIL mult_hex_%0d: got %b %b %b %b for product %h", k, bus.AhexU, bus.AhexL, bus.BhexU, bus.BhexL, prod);
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 300; i++) begin
         logic [3:0] r;
         r = 4'($urandom);
         apply(($urandom_range(0, 15) == 0), r[0], r[1], r[2], 8'($urandom));
         n_vec++;
         if ({bus.Aval, bus.Bval, bus.X, bus.M} !== {m_a, m_b, m_x, m_b[0]}) begin
            n_err++; $display("FAIL random_%0d: got A=%h B=%h X=%b M=%b, want %h %h %b %b", i, bus.Aval, bus.Bval, bus.X, bus.M, m_a, m_b, m_x, m_b[0]);
         end
         n_vec++;
         if ({bus.AhexU, bus.AhexL, bus.BhexU, bus.BhexL} !==
             {glyph[m_a[7:4]], glyph[m_a[3:0]], glyph[m_b[7:4]], glyph[m_b[3:0]]}) begin
            n_err++; $display("FAIL random_hex_%0d: got %b %b %b %b for A=%h B=%h", i, bus.AhexU, bus.AhexL, bus.BhexU, bus.BhexL, m_a, m_b);
         end
      end
   endtask

   initial begin
      glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      n_vec = 0;
      n_err = 0;
      m_a = 0; m_b = 0; m_x = 0;
      bus.Clr_ld = 1'b0; bus.Shift = 1'b0; bus.Add = 1'b0; bus.Sub = 1'b0; bus.S = 8'h00;
      test_reset();
      test_reset_midop();
      test_clr_ld();
      test_add_shift();
      test_sub_sign();
      test_combined();
      test_multiply();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
